// File: rtl/rca_result_collector_if.sv
// Result-collector bus: adder-side issue/capture signals plus the drain-side valid/ready port.
// The collector uses the slave modport; whoever drives the adder and consumes results uses master.
interface rca_result_collector_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;
    logic [CW-1:0]    count;
    logic             overflow;

    modport master (
        output in_valid, Sum, Cout, out_ready,
        input  issue_ready, out_valid, out_data, count, overflow
    );

    modport slave (
        input  in_valid, Sum, Cout, out_ready,
        output issue_ready, out_valid, out_data, count, overflow
    );
endinterface

// File: rtl/rca_result_collector.sv
// Tags real issue slots of the pipelined ripple-carry adder, captures {Cout,Sum} as each
// tagged result emerges, and queues it in a small FIFO guarded by a credit-style issue_ready.
module rca_result_collector #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    rca_result_collector_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] tag_vld;
    logic [WIDTH:0]     mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count_q;
    logic               overflow_q;

    logic               issue_ready;
    logic               issue_ok;
    logic               capture;
    logic               out_valid;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop_cap;
    logic               drop_issue;
    logic [SW-1:0]      credit_used;

    function automatic logic [SW-1:0] popcount(input logic [LATENCY-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < LATENCY; i++) begin
            n = n + SW'(v[i]);
        end
        return n;
    endfunction

    // Credit counts queued entries plus tagged results still inside the adder, so every
    // accepted issue is guaranteed a FIFO slot. Only registers feed issue_ready.
    always_comb begin
        credit_used = SW'(count_q) + popcount(tag_vld);
        issue_ready = credit_used < SW'(DEPTH);
        issue_ok    = bus.in_valid & issue_ready;
        drop_issue  = bus.in_valid & ~issue_ready;
        capture     = tag_vld[LATENCY-1];
        out_valid   = count_q != '0;
        pop         = out_valid & bus.out_ready;
        full        = count_q == CW'(DEPTH);
        wr_en       = capture & (~full | pop);
        drop_cap    = capture & full & ~pop;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tag_vld    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            tag_vld[0] <= issue_ok;
            for (int k = 1; k < LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
            end
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en & ~pop)      count_q <= count_q + 1'b1;
            else if (~wr_en & pop) count_q <= count_q - 1'b1;
            if (drop_issue | drop_cap) overflow_q <= 1'b1;
        end
    end

    // Storage is data only; the head is masked while empty so stale entries never show.
    always_ff @(posedge Clock) begin
        if (wr_en) mem[wr_ptr] <= {bus.Cout, bus.Sum};
    end

    assign bus.issue_ready = issue_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? mem[rd_ptr] : '0;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
endmodule
